// File: rtl/pipe_demux2.sv
// pipe_demux2 -- registered 1-to-2 steering stage (inverse of a 2:1 mux).
//
// One WIDTH-bit word per cycle is accepted on a valid/ready input and routed
// to output A (in_sel=0) or output B (in_sel=1). Each output owns a holding
// buffer, so a stalled consumer on one side never disturbs the other side.
//
// Handshake: every channel transfers on a cycle where valid & ready are both 1
// at the rising clock edge. A producer holds valid (and data) stable until the
// transfer; ready may be asserted independently of valid.
//
// Build option (macro DEMUX_SKID_EN):
//   defined   : 2-entry skid buffer per output; "can accept" comes from
//               registered state only, so a_ready/b_ready never reach in_ready
//               combinationally, and throughput is full with toggling ready.
//   undefined : 1-entry buffer per output; "can accept" = ~x_valid | x_ready.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        input handshake
//   in_sel                   destination: 0 = A, 1 = B (used only with in_valid)
//   in_data[WIDTH]           input word
//   a_valid/a_ready/a_data   output A channel
//   b_valid/b_ready/b_data   output B channel
//   a_state/b_state          debug: buffer state (0=EMPTY, 1=ONE, 2=TWO)

// Per-output holding buffer. Output word is always the head register, so the
// data holds while stalled and keeps its last value after the final pop.
module pipe_demux2_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_accept,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  buf_state_t       state_q, state_nxt;
  logic [WIDTH-1:0] head_q, head_nxt;
  logic             pop;

  assign valid     = (state_q != ST_EMPTY);
  assign pop       = valid & ready;
  assign data      = head_q;
  assign state_dbg = state_q;

`ifdef DEMUX_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_nxt;

  // Registered-only acceptance: the second entry absorbs the word that
  // arrives in the cycle the consumer drops ready.
  assign can_accept = (state_q != ST_TWO);

  always_comb begin
    state_nxt = state_q;
    head_nxt  = head_q;
    skid_nxt  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_nxt = ST_ONE;
          head_nxt  = push_data;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_nxt = push_data;
        end else if (push) begin
          state_nxt = ST_TWO;
          skid_nxt  = push_data;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // No push can arrive here: can_accept is low in TWO.
        if (pop) begin
          state_nxt = ST_ONE;
          head_nxt  = skid_q;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else begin
      skid_q <= skid_nxt;
    end
  end
`else
  // Single entry: a new word may enter only if the current one leaves now.
  assign can_accept = (state_q == ST_EMPTY) | ready;

  always_comb begin
    state_nxt = state_q;
    head_nxt  = head_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_nxt = ST_ONE;
          head_nxt  = push_data;
        end
      end
      ST_ONE: begin
        // A push in ONE always coincides with a pop (see can_accept).
        if (push) begin
          head_nxt = push_data;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
    end else begin
      state_q <= state_nxt;
      head_q  <= head_nxt;
    end
  end

endmodule

module pipe_demux2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [1:0]       a_state,
  output logic [1:0]       b_state
);

  logic a_can, b_can;
  logic xfer, a_push, b_push;

  // Only the addressed side can stall the input; the idle side never blocks.
  assign in_ready = in_sel ? b_can : a_can;
  assign xfer     = in_valid & in_ready;
  assign a_push   = xfer & ~in_sel;
  assign b_push   = xfer &  in_sel;

  pipe_demux2_buf #(.WIDTH(WIDTH)) u_buf_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (a_push),
    .push_data  (in_data),
    .ready      (a_ready),
    .valid      (a_valid),
    .data       (a_data),
    .can_accept (a_can),
    .state_dbg  (a_state)
  );

  pipe_demux2_buf #(.WIDTH(WIDTH)) u_buf_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (b_push),
    .push_data  (in_data),
    .ready      (b_ready),
    .valid      (b_valid),
    .data       (b_data),
    .can_accept (b_can),
    .state_dbg  (b_state)
  );

endmodule

// File: tb/tb_pipe_demux2.sv
// Testbench for pipe_demux2: directed steering/stall/backpressure/reset cases
// plus a 1000-word random stress run, checked by a per-side expected queue.
module tb_pipe_demux2;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_sel = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         a_valid, b_valid;
  logic         a_ready = 1'b0;
  logic         b_ready = 1'b0;
  logic [W-1:0] a_data, b_data;
  logic [1:0]   a_state, b_state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic [W-1:0] exp_word;
  bit stress_done = 1'b0;

  pipe_demux2 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_state  (a_state),
    .b_state  (b_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard: pop-check, then record accepted inputs ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_valid && a_ready) begin
        if (exp_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_unexpected: got %h expected none at %0t", a_data, $time);
        end else begin
          exp_word = exp_a.pop_front();
          chk("a_pop_data", a_data, exp_word);
        end
      end
      if (b_valid && b_ready) begin
        if (exp_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected: got %h expected none at %0t", b_data, $time);
        end else begin
          exp_word = exp_b.pop_front();
          chk("b_pop_data", b_data, exp_word);
        end
      end
      if (in_valid && in_ready) begin
        if (in_sel) exp_b.push_back(in_data);
        else        exp_a.push_back(in_data);
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send(input logic sel, input logic [W-1:0] d);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1; in_sel = sel; in_data = d;
    while (!acc && n < 200) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout: got no in_ready expected accept of %h at %0t", d, $time);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    failures++;
    $display("FAIL watchdog: got no finish expected finish by 2ms");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    #12;
    chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
    chk("rst_a_data", a_data, 32'd0);
    chk("rst_b_data", b_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Steering
    a_ready = 1'b1; b_ready = 1'b1;
    send(1'b0, 32'hAAAAAAAA);
    chk("steer_a_valid", {31'd0, a_valid}, 32'd1);
    chk("steer_a_data", a_data, 32'hAAAAAAAA);
    chk("steer_b_idle", {31'd0, b_valid}, 32'd0);
    send(1'b1, 32'h55555555);
    chk("steer_b_valid", {31'd0, b_valid}, 32'd1);
    chk("steer_b_data", b_data, 32'h55555555);
    chk("steer_a_idle", {31'd0, a_valid}, 32'd0);
    idle(2);

    // Side stall: B full and stalled, A streams
    b_ready = 1'b0;
    send(1'b1, 32'h12345678);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h00000000; #1;
    chk("stall_in_ready_a", {31'd0, in_ready}, 32'd1);
    send(1'b0, 32'h00000000);
    send(1'b0, 32'hFFFFFFFF);
    chk("stall_a_data", a_data, 32'hFFFFFFFF);
    chk("stall_b_hold_valid", {31'd0, b_valid}, 32'd1);
    chk("stall_b_hold_data", b_data, 32'h12345678);
    b_ready = 1'b1;
    idle(3);
    chk("stall_drained", exp_a.size() + exp_b.size(), 32'd0);

    // Backpressure on A
    a_ready = 1'b0;
    send(1'b0, 32'hA5A5A5A5);
`ifdef DEMUX_SKID_EN
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h5A5A5A5A; #1;
    chk("bp_in_ready_one", {31'd0, in_ready}, 32'd1);
    send(1'b0, 32'h5A5A5A5A);
    chk("bp_a_state_two", {30'd0, a_state}, 32'd2);
`endif
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h0BAD0BAD; #1;
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    in_sel = 1'b1; #1;
    chk("bp_in_ready_idle_side", {31'd0, in_ready}, 32'd1);
    idle(3);
    chk("bp_a_hold", a_data, 32'hA5A5A5A5);
    a_ready = 1'b1;
    idle(4);
    chk("bp_drained", exp_a.size(), 32'd0);
    chk("bp_a_valid_after", {31'd0, a_valid}, 32'd0);

    // Same-cycle push + pop on A
    a_ready = 1'b0;
    send(1'b0, 32'h11111111);
    a_ready = 1'b1;
    send(1'b0, 32'hDDDDDDDD);
    chk("pp_a_data", a_data, 32'hDDDDDDDD);
    chk("pp_a_state_one", {30'd0, a_state}, 32'd1);
    idle(2);
    chk("pp_a_hold_after_pop", a_data, 32'hDDDDDDDD);

    // Asynchronous reset mid-stream
    a_ready = 1'b0;
    send(1'b0, 32'hCAFEF00D);
    chk("rst2_pre_a_valid", {31'd0, a_valid}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst2_a_valid", {31'd0, a_valid}, 32'd0);
    chk("rst2_b_valid", {31'd0, b_valid}, 32'd0);
    chk("rst2_a_data", a_data, 32'd0);
    chk("rst2_b_data", b_data, 32'd0);
    exp_a.delete(); exp_b.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Random stress
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          send(1'($urandom_range(0, 1)), $urandom);
        end
        stress_done = 1'b1;
      end
      begin
        while (!stress_done) begin
          @(posedge clk); #1;
          a_ready = 1'($urandom_range(0, 1));
          b_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    a_ready = 1'b1; b_ready = 1'b1;
    idle(6);
    chk("stress_a_drained", exp_a.size(), 32'd0);
    chk("stress_b_drained", exp_b.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
